// File: rtl/tt_um_priority_decoder_if.sv
// ---------------------------------------------------------------------------
// tt_um_priority_decoder_if
// Pin bundle of the priority-decoder tile. The Tiny Tapeout pin names are kept
// so that the bus maps directly onto the tile pads.
//   ui_in   [7:0]  code to decode
//   uio_in  [7:0]  [0]=in_valid, [1]=out_ready, [7:2] unused
//   uo_out  [7:0]  current one-hot beat
//   uio_out [7:0]  [2]=out_valid, [3]=beat, [4]=none, [5]=error, [6]=in_ready
//   uio_oe  [7:0]  bidirectional pad output enables
// Modports: master drives codes and consumes beats; slave is the decoder.
// ---------------------------------------------------------------------------
interface tt_um_priority_decoder_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_priority_decoder.sv
// ---------------------------------------------------------------------------
// tt_um_priority_decoder
// Inverse of the 16-input priority encoder. An 8-bit code (0x00-0x0F = index,
// NONE_CODE = nothing set) is accepted through a valid/ready handshake and the
// 16-bit one-hot result is returned over uo_out as two beats, low byte first.
// Codes that are neither an index nor NONE_CODE raise the error flag.
// Ports:
//   clk    single clock, all state changes on posedge
//   rst_n  synchronous active-low reset
//   ena    unused
//   bus    tt_um_priority_decoder_if.slave (see the interface for the pinout)
// Parameters:
//   NONE_CODE   code meaning "no input set"
//   ERR_STICKY  1: error held until reset; 0: error only for the bad code
// ---------------------------------------------------------------------------
module tt_um_priority_decoder #(
  parameter logic [7:0] NONE_CODE  = 8'hF0,
  parameter bit         ERR_STICKY = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  tt_um_priority_decoder_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [7:0] uo_q, uo_d;
  logic       out_valid_q, out_valid_d;
  logic       beat_q, beat_d;
  logic       none_q, none_d;
  logic       err_q, err_d;

  logic        in_valid, out_ready;
  logic [15:0] in_onehot, cap_onehot;
  logic        in_is_none, in_is_bad;

  function automatic logic [15:0] onehot_of(input logic [7:0] code);
    return (code[7:4] == 4'h0) ? (16'h0001 << code[3:0]) : 16'h0000;
  endfunction

  assign in_valid  = bus.uio_in[0];
  assign out_ready = bus.uio_in[1];

  // The low beat is issued on the accept edge, so it is decoded straight from
  // the pins; the high beat comes later from the captured code.
  assign in_onehot  = onehot_of(bus.ui_in);
  assign cap_onehot = onehot_of(code_q);
  assign in_is_none = (bus.ui_in == NONE_CODE);
  assign in_is_bad  = (bus.ui_in[7:4] != 4'h0) && !in_is_none;

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    uo_d        = uo_q;
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    none_d      = none_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = LO;
          code_d      = bus.ui_in;
          uo_d        = in_onehot[7:0];
          out_valid_d = 1'b1;
          beat_d      = 1'b0;
          none_d      = in_is_none;
          err_d       = in_is_bad | (ERR_STICKY & err_q);
        end
      end
      LO: begin
        if (out_ready) begin
          state_d = HI;
          uo_d    = cap_onehot[15:8];
          beat_d  = 1'b1;
        end
      end
      HI: begin
        if (out_ready) begin
          state_d     = IDLE;
          uo_d        = 8'h00;
          out_valid_d = 1'b0;
          beat_d      = 1'b0;
          none_d      = 1'b0;
          if (!ERR_STICKY) err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= 8'h00;
      uo_q        <= 8'h00;
      out_valid_q <= 1'b0;
      beat_q      <= 1'b0;
      none_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      uo_q        <= uo_d;
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      none_q      <= none_d;
      err_q       <= err_d;
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = {1'b0, (state_q == IDLE), err_q, none_q, beat_q,
                        out_valid_q, 2'b00};
  assign bus.uio_oe  = 8'b0111_1100;

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, bus.uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// ---------------------------------------------------------------------------
// tb_tt_um_priority_decoder
// Directed bench for the priority decoder. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, after the registers settled.
// uio_out reference: 0x40 idle, 0x04 beat0, 0x0C beat1, +0x10 none, +0x20 err.
// ---------------------------------------------------------------------------
module tb_tt_um_priority_decoder;

  logic clk;
  logic rst_n;
  logic ena;
  int   total;
  int   bad;

  tt_um_priority_decoder_if bus ();

  tt_um_priority_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] uo, input logic [7:0] uio);
    check({tag, ".uo_out"}, bus.uo_out, uo);
    check({tag, ".uio_out"}, bus.uio_out, uio);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    ena        = 1'b1;
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // Reset for two cycles
    tick();
    tick();
    check_out("reset", 8'h00, 8'h40);
    check("reset.uio_oe", bus.uio_oe, 8'h7C);
    rst_n = 1'b1;

    // Code 0x05 with out_ready high
    bus.ui_in = 8'h05; bus.uio_in = 8'h03;
    tick(); check_out("c05.beat0", 8'h20, 8'h04);
    bus.uio_in = 8'h02;
    tick(); check_out("c05.beat1", 8'h00, 8'h0C);
    tick(); check_out("c05.idle", 8'h00, 8'h40);

    // Code 0x0C with out_ready held low for three cycles
    bus.ui_in = 8'h0C; bus.uio_in = 8'h01;
    tick(); check_out("c0c.beat0", 8'h00, 8'h04);
    bus.uio_in = 8'h00;
    tick(); check_out("c0c.stall1", 8'h00, 8'h04);
    tick(); check_out("c0c.stall2", 8'h00, 8'h04);
    bus.uio_in = 8'h02;
    tick(); check_out("c0c.beat1", 8'h10, 8'h0C);
    tick(); check_out("c0c.idle", 8'h00, 8'h40);

    // Code 0xF0: none on both beats, cleared in idle. in_valid kept high
    // during HI to confirm no accept happens in the HI->IDLE cycle.
    bus.ui_in = 8'hF0; bus.uio_in = 8'h03;
    tick(); check_out("cf0.beat0", 8'h00, 8'h14);
    bus.uio_in = 8'h02;
    tick(); check_out("cf0.beat1", 8'h00, 8'h1C);
    bus.ui_in = 8'h01; bus.uio_in = 8'h03;
    tick(); check_out("cf0.idle", 8'h00, 8'h40);
    tick(); check_out("c01.beat0", 8'h02, 8'h04);
    bus.uio_in = 8'h02;
    tick(); check_out("c01.beat1", 8'h00, 8'h0C);
    tick(); check_out("c01.idle", 8'h00, 8'h40);

    // Code 0x37: malformed, error sticks afterwards
    bus.ui_in = 8'h37; bus.uio_in = 8'h03;
    tick(); check_out("c37.beat0", 8'h00, 8'h24);
    bus.uio_in = 8'h02;
    tick(); check_out("c37.beat1", 8'h00, 8'h2C);
    tick(); check_out("c37.idle", 8'h00, 8'h60);

    // Code 0x00 while error is still held
    bus.ui_in = 8'h00; bus.uio_in = 8'h03;
    tick(); check_out("c00.beat0", 8'h01, 8'h24);
    bus.uio_in = 8'h02;
    tick(); check_out("c00.beat1", 8'h00, 8'h2C);
    tick(); check_out("c00.idle", 8'h00, 8'h60);

    // Reset clears the sticky error
    rst_n = 1'b0; bus.uio_in = 8'h00;
    tick(); check_out("errclr", 8'h00, 8'h40);
    rst_n = 1'b1;

    // Busy: a second code offered during LO is ignored
    bus.ui_in = 8'h0B; bus.uio_in = 8'h01;
    tick(); check_out("busy.beat0", 8'h00, 8'h04);
    bus.ui_in = 8'h0F; bus.uio_in = 8'h01;
    tick(); check_out("busy.hold", 8'h00, 8'h04);
    bus.uio_in = 8'h02;
    tick(); check_out("busy.beat1", 8'h08, 8'h0C);

    // Reset during HI with in_valid high: abort, stay idle, no beat
    rst_n = 1'b0; bus.ui_in = 8'h0F; bus.uio_in = 8'h03;
    tick(); check_out("rsthi", 8'h00, 8'h40);
    rst_n = 1'b1; bus.uio_in = 8'h02;
    tick(); check_out("rsthi.after", 8'h00, 8'h40);

    // Highest index after reset
    bus.ui_in = 8'h0F; bus.uio_in = 8'h03;
    tick(); check_out("c0f.beat0", 8'h00, 8'h04);
    bus.uio_in = 8'h02;
    tick(); check_out("c0f.beat1", 8'h80, 8'h0C);
    tick(); check_out("c0f.idle", 8'h00, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
